// File: rtl/float_type_gen.sv
// rtl/float_type_gen.sv - LFSR-driven IEEE-754 single-precision operand stream of a requested class
module float_type_gen #(
    parameter int          CNT_W     = 8,
    parameter logic [31:0] LFSR_POLY = 32'h80200003
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [4:0]       float_type,
    input  logic             sign,
    input  logic             alt_sign,
    input  logic [CNT_W-1:0] count,
    input  logic [31:0]      seed,
    output logic [31:0]      num,
    output logic             num_valid,
    input  logic             num_ready,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [4:0] T_ZERO = 5'b00001;
    localparam logic [4:0] T_NORM = 5'b00010;
    localparam logic [4:0] T_SUB  = 5'b00100;
    localparam logic [4:0] T_INF  = 5'b01000;
    localparam logic [4:0] T_NAN  = 5'b10000;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t             state, state_n;
    logic [31:0]        lfsr, lfsr_n;
    logic [CNT_W-1:0]   remaining, remaining_n;
    logic [4:0]         type_q, type_n;
    logic               sign_q, sign_n;
    logic               alt_q, alt_n;
    logic               done_n, err_n;
    logic               handshake;
    logic [7:0]         e;
    logic [22:0]        f;

    function automatic logic is_onehot(input logic [4:0] t);
        return (t != 5'd0) && ((t & (t - 5'd1)) == 5'd0);
    endfunction

    // Right-shifting Galois step; taps fold in when the bit shifted out is 1.
    function automatic logic [31:0] galois_step(input logic [31:0] l);
        return l[0] ? ((l >> 1) ^ LFSR_POLY) : (l >> 1);
    endfunction

    assign num_valid = (state == RUN);
    assign busy      = (state == RUN);
    assign handshake = num_valid & num_ready;
    assign e         = lfsr[30:23];
    assign f         = lfsr[22:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            lfsr      <= 32'h1;
            remaining <= '0;
            type_q    <= 5'd0;
            sign_q    <= 1'b0;
            alt_q     <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            lfsr      <= lfsr_n;
            remaining <= remaining_n;
            type_q    <= type_n;
            sign_q    <= sign_n;
            alt_q     <= alt_n;
            done      <= done_n;
            err       <= err_n;
        end
    end

    always_comb begin
        state_n     = state;
        lfsr_n      = lfsr;
        remaining_n = remaining;
        type_n      = type_q;
        sign_n      = sign_q;
        alt_n       = alt_q;
        done_n      = 1'b0;
        err_n       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (!is_onehot(float_type)) begin
                        err_n = 1'b1;
                    end else if (count == '0) begin
                        done_n = 1'b1;
                    end else begin
                        state_n     = RUN;
                        type_n      = float_type;
                        sign_n      = sign;
                        alt_n       = alt_sign;
                        remaining_n = count;
                        lfsr_n      = (seed == 32'h0) ? 32'h1 : seed;
                    end
                end
            end
            RUN: begin
                if (handshake) begin
                    lfsr_n      = galois_step(lfsr);
                    remaining_n = remaining - CNT_W'(1);
                    if (alt_q) begin
                        sign_n = ~sign_q;
                    end
                    if (remaining == CNT_W'(1)) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Field forcing keeps every operand inside the requested class.
    always_comb begin
        num = 32'h0;
        if (state == RUN) begin
            case (type_q)
                T_ZERO:  num = {sign_q, 8'h00, 23'h0};
                T_NORM:  num = {sign_q, (e == 8'h00) ? 8'h01 : (e == 8'hFF) ? 8'hFE : e, f};
                T_SUB:   num = {sign_q, 8'h00, (f == 23'h0) ? 23'h1 : f};
                T_INF:   num = {sign_q, 8'hFF, 23'h0};
                T_NAN:   num = {sign_q, 8'hFF, (f == 23'h0) ? 23'h400000 : f};
                default: num = 32'h0;
            endcase
        end
    end

endmodule

// File: tb/tb_float_type_gen.sv
// tb/tb_float_type_gen.sv - self-checking bench for float_type_gen
module tb_float_type_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        start = 1'b0;
    logic [4:0]  float_type = 5'd0;
    logic        sign = 1'b0;
    logic        alt_sign = 1'b0;
    logic [7:0]  count = 8'd0;
    logic [31:0] seed = 32'h0;
    logic [31:0] num;
    logic        num_valid;
    logic        num_ready = 1'b1;
    logic        busy;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    float_type_gen dut (
        .clk(clk), .reset(reset), .start(start), .float_type(float_type),
        .sign(sign), .alt_sign(alt_sign), .count(count), .seed(seed),
        .num(num), .num_valid(num_valid), .num_ready(num_ready),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [4:0] classify(input logic [31:0] v);
        if (v[30:23] == 8'h00) return (v[22:0] == 0) ? 5'b00001 : 5'b00100;
        if (v[30:23] == 8'hFF) return (v[22:0] == 0) ? 5'b01000 : 5'b10000;
        return 5'b00010;
    endfunction

    function automatic logic [31:0] next_lfsr(input logic [31:0] l);
        logic [31:0] r;
        r = l / 2;
        if (l % 2 == 1) r = r ^ 32'h80200003;
        return r;
    endfunction

    // Operand for a class: start from raw LFSR bits and coerce into the class.
    function automatic logic [31:0] make_operand(input logic [4:0] t, input logic s, input logic [31:0] l);
        logic [7:0]  ex;
        logic [22:0] fr;
        ex = l[30:23];
        fr = l[22:0];
        case (t)
            5'b00001: return {s, 31'h0};
            5'b00010: begin
                if (ex == 0) ex = 1;
                if (ex == 255) ex = 254;
                return {s, ex, fr};
            end
            5'b00100: return {s, 8'h00, (fr == 0) ? 23'h1 : fr};
            5'b01000: return {s, 8'hFF, 23'h0};
            default:  return {s, 8'hFF, (fr == 0) ? 23'h400000 : fr};
        endcase
    endfunction

    // Model: the whole expected stream of a request is generated up front.
    logic [31:0] mq[$];
    logic [4:0]  m_type = 5'd0;
    bit          m_done = 1'b0;
    bit          m_err  = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            m_done = 1'b0;
            m_err  = 1'b0;
        end else begin
            m_done = 1'b0;
            m_err  = 1'b0;
            if (mq.size() > 0) begin
                if (num_ready) begin
                    void'(mq.pop_front());
                    if (mq.size() == 0) m_done = 1'b1;
                end
            end else if (start) begin
                if ($countones(float_type) != 1) begin
                    m_err = 1'b1;
                end else if (count == 0) begin
                    m_done = 1'b1;
                end else begin
                    logic [31:0] l;
                    logic        s;
                    l = (seed == 0) ? 32'h1 : seed;
                    s = sign;
                    m_type = float_type;
                    for (int i = 0; i < count; i++) begin
                        mq.push_back(make_operand(float_type, s, l));
                        l = next_lfsr(l);
                        if (alt_sign) s = ~s;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en && !reset) begin
            logic have;
            have = (mq.size() > 0);
            check("num_valid", {31'h0, num_valid}, {31'h0, have});
            check("busy", {31'h0, busy}, {31'h0, have});
            check("done", {31'h0, done}, {31'h0, m_done});
            check("err", {31'h0, err}, {31'h0, m_err});
            check("num", num, have ? mq[0] : 32'h0);
            if (num_valid) check("class", {27'h0, classify(num)}, {27'h0, m_type});
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [4:0] t, input logic s, input logic a,
                       input logic [7:0] c, input logic [31:0] sd);
        float_type = t;
        sign       = s;
        alt_sign   = a;
        count      = c;
        seed       = sd;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int i;
        i = 0;
        while (busy && i < bound) begin
            tick();
            i++;
        end
        check("idle_timeout", {31'h0, busy}, 32'h0);
        tick();
    endtask

    initial begin
        reset = 1'b1;
        #1;
        check("rst_num", num, 32'h0);
        check("rst_ctl", {27'h0, num_valid, busy, done, err}, 32'h0);
        tick();
        tick();
        reset  = 1'b0;
        cmp_en = 1'b1;
        tick();

        // Zero stream, fixed sign
        num_ready = 1'b1;
        req(5'b00001, 1'b1, 1'b0, 8'd3, 32'h1);
        check("t1_n0", num, 32'h80000000);
        tick(); check("t1_n1", num, 32'h80000000);
        tick(); check("t1_n2", num, 32'h80000000);
        tick(); check("t1_done", {30'h0, done, num_valid}, 32'h2);
        tick();

        // Infinity, alternating sign
        req(5'b01000, 1'b0, 1'b1, 8'd4, 32'h7);
        check("t2_n0", num, 32'h7F800000);
        tick(); check("t2_n1", num, 32'hFF800000);
        tick(); check("t2_n2", num, 32'h7F800000);
        tick(); check("t2_n3", num, 32'hFF800000);
        tick(); check("t2_done", {31'h0, done}, 32'h1);
        tick();

        // Forced fields
        req(5'b00010, 1'b0, 1'b0, 8'd1, 32'h1);
        check("t3_norm", num, 32'h00800001);
        wait_idle(10);
        req(5'b00100, 1'b0, 1'b0, 8'd1, 32'h3F800000);
        check("t3_sub", num, 32'h00000001);
        wait_idle(10);
        req(5'b10000, 1'b0, 1'b0, 8'd1, 32'h0);
        check("t3_nan", num, 32'h7F800001);
        wait_idle(10);

        // Backpressure
        num_ready = 1'b0;
        req(5'b00010, 1'b0, 1'b0, 8'd2, 32'h12345678);
        for (int i = 0; i < 5; i++) begin
            check("t4_hold", num, 32'h12345678);
            tick();
        end
        num_ready = 1'b1;
        tick();
        check("t4_mid", {31'h0, num_valid}, 32'h1);
        tick();
        check("t4_done", {30'h0, done, num_valid}, 32'h2);
        tick();

        // Illegal and edge requests
        req(5'b00011, 1'b0, 1'b0, 8'd4, 32'h1);
        check("t5_err", {30'h0, err, num_valid}, 32'h2);
        tick(); check("t5_err_pulse", {31'h0, err}, 32'h0);
        req(5'b00010, 1'b0, 1'b0, 8'd0, 32'h1);
        check("t5_cnt0", {29'h0, done, err, num_valid}, 32'h4);
        tick();
        num_ready = 1'b0;
        req(5'b00100, 1'b0, 1'b0, 8'd3, 32'h5);
        float_type = 5'b01000;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t5_ignore", num, 32'h00000005);
        num_ready = 1'b1;
        wait_idle(20);

        // Reset mid-run
        req(5'b00010, 1'b1, 1'b1, 8'd200, 32'hCAFEF00D);
        for (int i = 0; i < 10; i++) tick();
        #2;
        reset = 1'b1;
        #1;
        check("t6_num", num, 32'h0);
        check("t6_ctl", {28'h0, num_valid, busy, done, err}, 32'h0);
        tick();
        reset = 1'b0;
        tick();
        check("t6_nodone", {31'h0, done}, 32'h0);
        req(5'b01000, 1'b1, 1'b0, 8'd2, 32'h9);
        check("t6_new", num, 32'hFF800000);
        wait_idle(10);

        // Long random-content runs with random backpressure
        for (int k = 0; k < 3; k++) begin
            logic [4:0] t;
            t = (k == 0) ? 5'b00010 : (k == 1) ? 5'b00100 : 5'b10000;
            num_ready = 1'b1;
            req(t, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'd255, $urandom);
            for (int i = 0; i < 2000 && busy; i++) begin
                num_ready = 1'($urandom_range(0, 3) != 0);
                tick();
            end
            num_ready = 1'b1;
            wait_idle(300);
        end

        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
